// File: rtl/text_overlay_pkg.sv
// Shared constants and types for the text overlay renderer and its font ROM.
package text_pkg;

  localparam logic [7:0] SPACE_CODE = 8'h20;
  localparam int unsigned GLYPH_W = 8;
  localparam int unsigned GLYPH_H = 8;

  typedef logic [7:0] char_code_t;

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_t;

endpackage

// File: rtl/text_overlay_font.sv
// 8x8 font ROM with a registered row output; row 0 is the top of the glyph,
// bit 7 the leftmost pixel. Codes without a glyph return an all-zero row.
module font_rom8x8
  import text_pkg::*;
(
  input  logic       clk,
  input  char_code_t code,
  input  logic [2:0] row,
  output logic [7:0] bitmap
);

  function automatic logic [63:0] glyph(input char_code_t c);
    case (c)
      8'h20: glyph = 64'h0000_0000_0000_0000;
      8'h3A: glyph = 64'h0018_1800_1818_0000;
      8'h30: glyph = 64'h3C66_6E76_6666_3C00;
      8'h31: glyph = 64'h2070_2020_2020_7000;
      8'h32: glyph = 64'h3C66_060C_3060_7E00;
      8'h33: glyph = 64'h3C66_061C_0666_3C00;
      8'h34: glyph = 64'h0C1C_3C6C_7E0C_0C00;
      8'h35: glyph = 64'h7E60_7C06_0666_3C00;
      8'h36: glyph = 64'h3C60_7C66_6666_3C00;
      8'h37: glyph = 64'h7E06_0C18_3030_3000;
      8'h38: glyph = 64'h3C66_663C_6666_3C00;
      8'h39: glyph = 64'h3C66_663E_060C_3800;
      8'h41: glyph = 64'h183C_6666_7E66_6600;
      8'h43: glyph = 64'h3C66_6060_6066_3C00;
      8'h45: glyph = 64'h7E60_607C_6060_7E00;
      8'h46: glyph = 64'h7E60_607C_6060_6000;
      8'h47: glyph = 64'h3C66_606E_6666_3C00;
      8'h4B: glyph = 64'h666C_7870_786C_6600;
      8'h4E: glyph = 64'h6676_7E7E_6E66_6600;
      8'h4F: glyph = 64'h3C66_6666_6666_3C00;
      8'h50: glyph = 64'h7C66_667C_6060_6000;
      8'h52: glyph = 64'h7C66_667C_786C_6600;
      8'h53: glyph = 64'h3C66_603C_0666_3C00;
      8'h54: glyph = 64'hFF18_1818_1818_1800;
      8'h59: glyph = 64'h6666_663C_1818_1800;
      default: glyph = '0;
    endcase
  endfunction

  logic [63:0] g;

  always_comb g = glyph(code);

  always_ff @(posedge clk) bitmap <= g[{~row, 3'b000} +: 8];

endmodule

// File: rtl/text_overlay.sv
// Character-buffer text overlay: 3-cycle pixel pipeline, clear engine, scaling.
// Optional per-character blink attribute (code bit 7) under `TEXT_BLINK_EN.
module text_overlay
  import text_pkg::*;
#(
  parameter int unsigned COLS         = 16,
  parameter int unsigned ROWS         = 2,
  parameter int unsigned ORIGIN_X     = 0,
  parameter int unsigned ORIGIN_Y     = 0,
  parameter int unsigned SCALE_LOG2   = 1,
  parameter int unsigned COORD_W      = 10,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [$clog2(COLS*ROWS)-1:0]  wr_addr,
  input  logic [7:0]                    wr_data,
  input  logic                          clear,
  output logic                          busy,
  input  logic [COORD_W-1:0]            pix_x,
  input  logic [COORD_W-1:0]            pix_y,
  input  logic                          pix_valid,
  input  logic                          frame_tick,
  output logic                          text_on,
  output logic                          text_valid
);

  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned AW    = $clog2(CELLS);
  localparam int unsigned REG_W = (COLS * GLYPH_W) << SCALE_LOG2;
  localparam int unsigned REG_H = (ROWS * GLYPH_H) << SCALE_LOG2;

  // Stage 1: region test and cell/glyph addressing
  logic [COORD_W-1:0] rel_x, rel_y, col, row;
  logic               in_region;
  logic [AW-1:0]      cell_idx;
  logic [2:0]         gx, gy;

  always_comb begin
    rel_x = pix_x - COORD_W'(ORIGIN_X);
    rel_y = pix_y - COORD_W'(ORIGIN_Y);
    // origin test on the raw coordinate stops a wrapped rel_x/rel_y hitting the region
    in_region = (32'(pix_x) >= ORIGIN_X) && (32'(pix_y) >= ORIGIN_Y) &&
                (32'(rel_x) < REG_W) && (32'(rel_y) < REG_H);
    col = rel_x >> (3 + SCALE_LOG2);
    row = rel_y >> (3 + SCALE_LOG2);
    cell_idx = in_region ? AW'(32'(row) * COLS + 32'(col)) : '0;
    gx = rel_x[SCALE_LOG2 +: 3];
    gy = rel_y[SCALE_LOG2 +: 3];
  end

  logic          s1_lit, s1_valid, s2_lit, s2_valid, s3_lit, s3_valid;
  logic [AW-1:0] s1_idx;
  logic [2:0]    s1_gx, s1_gy, s2_gx, s2_gy, s3_gx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_lit   <= 1'b0;
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_gx    <= '0;
      s1_gy    <= '0;
      s2_lit   <= 1'b0;
      s2_valid <= 1'b0;
      s2_gx    <= '0;
      s2_gy    <= '0;
      s3_lit   <= 1'b0;
      s3_valid <= 1'b0;
      s3_gx    <= '0;
    end else begin
      s1_lit   <= in_region & pix_valid;
      s1_valid <= pix_valid;
      s1_idx   <= cell_idx;
      s1_gx    <= gx;
      s1_gy    <= gy;
      s2_lit   <= s1_lit;
      s2_valid <= s1_valid;
      s2_gx    <= s1_gx;
      s2_gy    <= s1_gy;
      s3_lit   <= s2_lit;
      s3_valid <= s2_valid;
      s3_gx    <= s2_gx;
    end
  end

  // Clear engine
  clr_state_t    state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (clear) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
      CLEAR: begin
        if (cnt == AW'(CELLS - 1)) state_nx = IDLE;
        else cnt_nx = cnt + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb busy = (state == CLEAR);

  // Character buffer: one write port shared by host and clear engine, one read port
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  char_code_t    mem_wdata;
  char_code_t    mem [CELLS];
  char_code_t    rd_code;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = SPACE_CODE;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt;
    end else if (wr_en && (32'(wr_addr) < CELLS)) begin
      mem_we    = 1'b1;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    rd_code <= mem[s1_idx];
  end

  char_code_t rom_code;
  logic [7:0] bitmap;
  logic       s3_blank;

`ifdef TEXT_BLINK_EN
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] frame_cnt;
  logic          phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
      s3_blank  <= 1'b0;
    end else begin
      if (frame_tick) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          phase     <= ~phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
      s3_blank <= rd_code[7] & phase;
    end
  end

  always_comb rom_code = {1'b0, rd_code[6:0]};
`else
  logic unused_frame_tick;

  always_comb begin
    unused_frame_tick = frame_tick;
    rom_code          = rd_code;
    s3_blank          = 1'b0;
  end
`endif

  font_rom8x8 u_font (
    .clk    (clk),
    .code   (rom_code),
    .row    (s2_gy),
    .bitmap (bitmap)
  );

  always_comb begin
    text_on    = s3_lit & ~s3_blank & bitmap[~s3_gx];
    text_valid = s3_valid;
  end

endmodule

// File: tb/tb_text_overlay.sv
// Directed self-checking bench for text_overlay (16x2 cells, 2x scale, origin 0).
module tb_text_overlay;

`ifdef TEXT_BLINK_EN
  localparam int unsigned TB_BLINK = 2;
`else
  localparam int unsigned TB_BLINK = 30;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       clear;
  logic       busy;
  logic [9:0] pix_x, pix_y;
  logic       pix_valid;
  logic       frame_tick;
  logic       text_on;
  logic       text_valid;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] shadow [32];

  text_overlay #(
    .COLS(16), .ROWS(2), .ORIGIN_X(0), .ORIGIN_Y(0),
    .SCALE_LOG2(1), .COORD_W(10), .BLINK_FRAMES(TB_BLINK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear(clear), .busy(busy), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .frame_tick(frame_tick), .text_on(text_on), .text_valid(text_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hand-entered glyphs for the codes the bench writes
  function automatic logic [7:0] glyph_row(input logic [7:0] c, input int gy);
    logic [63:0] g;
    case (c)
      8'h30:   g = 64'h3C66_6E76_6666_3C00;
      8'h31:   g = 64'h2070_2020_2020_7000;
      8'h54:   g = 64'hFF18_1818_1818_1800;
      default: g = '0;
    endcase
    return g[63 - 8*gy -: 8];
  endfunction

  function automatic logic exp_on(input int x, input int y);
    logic [7:0] r;
    if (x >= 256 || y >= 32) return 1'b0;
    r = glyph_row(shadow[(y / 16) * 16 + x / 16], (y / 2) % 8);
    return r[7 - (x / 2) % 8];
  endfunction

  task automatic wr(input int addr, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_addr = 5'(addr);
    wr_data = data;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic probe(input int x, input int y, output logic on);
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    pix_valid = 1'b1;
    repeat (3) @(negedge clk);
    on        = text_on;
    pix_valid = 1'b0;
  endtask

  // Streams x=0..259, y=0..33 and compares every output against the model
  task automatic scan(output int errs);
    logic [1:0] q[$];
    logic [1:0] e;
    int total;
    total = 260 * 34;
    errs  = 0;
    for (int i = 0; i < total + 3; i++) begin
      if (i >= 3) begin
        e = q.pop_front();
        if (text_valid !== e[1] || text_on !== e[0]) errs++;
      end
      if (i < total) begin
        pix_x     = 10'(i % 260);
        pix_y     = 10'(i / 260);
        pix_valid = 1'b1;
        q.push_back({1'b1, exp_on(i % 260, i / 260)});
      end else begin
        pix_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic on;
    int   cnt, guard, errs;
    logic exp_blink;

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; clear = 1'b0;
    pix_x = '0; pix_y = '0; pix_valid = 1'b0; frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_text_on", text_on, 0);
    check("rst_text_valid", text_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill with '1', then clear with a host write to cell 5 in the clear cycle
    for (int i = 0; i < 32; i++) wr(i, 8'h31);
    probe(4, 0, on);
    check("prefill_cell0", on, 1);
    clear = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'h31;
    @(negedge clk);
    clear = 1'b0; wr_en = 1'b0;
    cnt = 0; guard = 0;
    while (busy === 1'b1 && guard < 200) begin
      cnt++;
      clear = (cnt == 8);
      wr_en = (cnt == 4);
      wr_addr = 5'd6;
      wr_data = 8'h31;
      @(negedge clk);
      guard++;
    end
    wr_en = 1'b0; clear = 1'b0;
    check("busy_len", cnt, 32);
    for (int i = 0; i < 32; i++) shadow[i] = 8'h20;
    probe(5 * 16 + 4, 0, on);
    check("cell5_cleared", on, 0);
    probe(6 * 16 + 4, 0, on);
    check("cell6_busy_write_dropped", on, 0);
    scan(errs);
    check("scan_blank_errs", errs, 0);

    // Glyphs at the region corners
    wr(0, 8'h31);  shadow[0]  = 8'h31;
    wr(15, 8'h54); shadow[15] = 8'h54;
    wr(16, 8'h31); shadow[16] = 8'h31;
    wr(31, 8'h30); shadow[31] = 8'h30;

    pix_x = 10'd2; pix_y = 10'd2; pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
    check("lat1", text_on, 0);
    @(negedge clk);
    check("lat2", text_on, 0);
    @(negedge clk);
    check("lat3", text_on, 1);
    check("lat3_valid", text_valid, 1);
    @(negedge clk);
    check("lat4", text_on, 0);
    check("lat4_valid", text_valid, 0);

    probe(3, 2, on);   check("px_3_2", on, 1);
    probe(4, 0, on);   check("px_4_0", on, 1);
    probe(5, 0, on);   check("px_5_0", on, 1);
    probe(3, 0, on);   check("px_3_0", on, 0);
    probe(6, 0, on);   check("px_6_0", on, 0);
    probe(255, 0, on); check("right_edge_in", on, 1);
    probe(256, 0, on); check("right_edge_out", on, 0);
    probe(4, 16, on);  check("row1_cell16", on, 1);
    probe(4, 32, on);  check("bottom_edge_out", on, 0);
    pix_x = 10'd4; pix_y = 10'd0; pix_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("invalid_pixel", text_on, 0);
    scan(errs);
    check("scan_glyph_errs", errs, 0);

    // Blink attribute; without the macro 0xB0 has no glyph and ticks do nothing
    wr(1, 8'hB0);
    wr(2, 8'h30);
    for (int f = 0; f < 5; f++) begin
`ifdef TEXT_BLINK_EN
      exp_blink = ((f / 2) % 2) == 0;
`else
      exp_blink = 1'b0;
`endif
      probe(20, 0, on);
      check($sformatf("blink_cell_f%0d", f), on, exp_blink);
      probe(36, 0, on);
      check($sformatf("plain_cell_f%0d", f), on, 1);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end

    // Reset in the middle of a clear
    for (int i = 0; i < 32; i++) wr(i, 8'h31);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (7) @(negedge clk);
    pix_x = 10'd68; pix_y = 10'd16; pix_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    check("pre_reset_text_on", text_on, 1);
    rst_n = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_text_on", text_on, 0);
    check("async_text_valid", text_valid, 0);
    pix_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", busy, 0);
    probe(4, 0, on);           check("cell0_cleared", on, 0);
    probe(9 * 16 + 4, 0, on);  check("cell9_cleared", on, 0);
    probe(10 * 16 + 4, 0, on); check("cell10_kept", on, 1);
    probe(68, 16, on);         check("cell20_kept", on, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
